// File: rtl/ccd_pkg.sv
// ccd_pkg: types and constants for the sensor capture front end.
// Holds the capture FSM state type and the default widths shared with the
// downstream Bayer-to-grayscale / edge-filter stage.
package ccd_pkg;

    localparam int CCD_DATA_W     = 12;    // sensor pixel width
    localparam int CCD_X_W        = 11;    // column coordinate width
    localparam int CCD_Y_W        = 11;    // row coordinate width
    localparam int CCD_LINE_WIDTH = 1280;  // active pixels per line
    localparam int CCD_FRAME_W    = 32;    // completed-frame counter width

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        WAIT_SOF,
        ACTIVE
    } ccd_state_t;

endpackage

// File: rtl/ccd_edge_det.sv
// ccd_edge_det: 1-bit rise/fall detector.
// Compares the input with its value on the previous clock.
// Ports:
//   iCLK    pixel clock
//   iRST    synchronous active-high reset (history returns to RESET_VAL)
//   i_sig   signal to watch (already registered by the caller)
//   o_rise  i_sig is 1 now and was 0 last cycle
//   o_fall  i_sig is 0 now and was 1 last cycle
module ccd_edge_det #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_prev <= RESET_VAL;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;
    assign o_fall = ~i_sig & r_prev;

endmodule

// File: rtl/ccd_capture.sv
// ccd_capture: camera sensor capture stage.
// Registers the raw sensor bus, gates capture with start/stop commands so that
// only whole frames are forwarded, and generates per-pixel column/row
// coordinates plus the data-valid strobe for the downstream filter stage.
// Ports:
//   iCLK, iRST          pixel clock, synchronous active-high reset
//   iDATA, iFVAL, iLVAL raw sensor pixel, frame valid, line valid
//   iSTART, iEND        one-cycle arm / stop commands (iEND wins on a tie)
//   oDATA, oDVAL        registered pixel and its valid strobe
//   oX_Cont, oY_Cont    coordinates of the pixel on oDATA (held while invalid)
//   oFrame_Cont         count of completed captured frames
//   oBusy               high whenever the FSM is not IDLE
module ccd_capture
    import ccd_pkg::*;
#(
    parameter int DATA_W     = CCD_DATA_W,
    parameter int X_W        = CCD_X_W,
    parameter int Y_W        = CCD_Y_W,
    parameter int LINE_WIDTH = CCD_LINE_WIDTH
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic [DATA_W-1:0]      iDATA,
    input  logic                   iFVAL,
    input  logic                   iLVAL,
    input  logic                   iSTART,
    input  logic                   iEND,
    output logic [DATA_W-1:0]      oDATA,
    output logic                   oDVAL,
    output logic [X_W-1:0]         oX_Cont,
    output logic [Y_W-1:0]         oY_Cont,
    output logic [CCD_FRAME_W-1:0] oFrame_Cont,
    output logic                   oBusy
);

    localparam logic [X_W-1:0] X_LAST = X_W'(LINE_WIDTH - 1);

    // Stage 1: registered copies of the sensor bus
    logic [DATA_W-1:0] r_mdata;
    logic              r_mfval;
    logic              r_mlval;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_mdata <= '0;
            r_mfval <= 1'b0;
            r_mlval <= 1'b0;
        end else begin
            r_mdata <= iDATA;
            r_mfval <= iFVAL;
            r_mlval <= iLVAL;
        end
    end

    logic w_fval_rise;
    logic w_fval_fall;
    logic w_lval_rise_unused;
    logic w_lval_fall;

    ccd_edge_det #(.RESET_VAL(1'b0)) u_fval_edge (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .i_sig  (r_mfval),
        .o_rise (w_fval_rise),
        .o_fall (w_fval_fall)
    );

    ccd_edge_det #(.RESET_VAL(1'b0)) u_lval_edge (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .i_sig  (r_mlval),
        .o_rise (w_lval_rise_unused),
        .o_fall (w_lval_fall)
    );

    // Stage 2: FSM, coordinate counters and output registers
    ccd_state_t             r_state;
    logic                   r_stop_pend;
    logic [X_W-1:0]         r_x;        // coordinate the next valid pixel takes
    logic [Y_W-1:0]         r_y;
    logic [DATA_W-1:0]      r_data;
    logic                   r_dval;
    logic [X_W-1:0]         r_xo;
    logic [Y_W-1:0]         r_yo;
    logic [CCD_FRAME_W-1:0] r_frame;
    logic                   w_pix_valid;

    assign w_pix_valid = (r_state == ACTIVE) && r_mlval;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state     <= IDLE;
            r_stop_pend <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_data      <= '0;
            r_dval      <= 1'b0;
            r_xo        <= '0;
            r_yo        <= '0;
            r_frame     <= '0;
        end else begin
            r_data <= r_mdata;
            r_dval <= w_pix_valid;
            if (w_pix_valid) begin
                r_xo <= r_x;
                r_yo <= r_y;
            end

            case (r_state)
                IDLE: begin
                    if (iSTART && !iEND) begin
                        r_state <= SYNC;
                    end
                end
                SYNC: begin
                    // Let any frame already in flight pass before arming
                    if (iEND) begin
                        r_state <= IDLE;
                    end else if (!r_mfval) begin
                        r_state <= WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    if (iEND) begin
                        r_state <= IDLE;
                    end else if (w_fval_rise) begin
                        r_state <= ACTIVE;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                ACTIVE: begin
                    if (iEND) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_fval_fall) begin
                        r_frame     <= r_frame + CCD_FRAME_W'(1);
                        r_x         <= '0;
                        r_y         <= '0;
                        r_stop_pend <= 1'b0;
                        // A stop arriving on the closing cycle still ends capture
                        r_state     <= (r_stop_pend || iEND) ? IDLE : WAIT_SOF;
                    end else if (w_pix_valid) begin
                        if (r_x == X_LAST) begin
                            r_x <= '0;
                            r_y <= r_y + Y_W'(1);
                        end else begin
                            r_x <= r_x + X_W'(1);
                        end
                    end else if (w_lval_fall && (r_x != '0)) begin
                        // Short line: next line still starts at column 0
                        r_x <= '0;
                        r_y <= r_y + Y_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign oDATA       = r_data;
    assign oDVAL       = r_dval;
    assign oX_Cont     = r_xo;
    assign oY_Cont     = r_yo;
    assign oFrame_Cont = r_frame;
    assign oBusy       = (r_state != IDLE);

endmodule

// File: tb/tb_ccd_capture.sv
// tb_ccd_capture: scenario bench for ccd_capture.
// Frames are described as line-length lists; the expected pixel stream
// (data, column, row, drive cycle) is derived from those lists with plain
// arithmetic and compared against every oDVAL pulse seen on the outputs.
module tb_ccd_capture;

    localparam int DW = 12;
    localparam int XW = 11;
    localparam int YW = 11;
    localparam int LW = 8;

    logic          iCLK   = 1'b0;
    logic          iRST   = 1'b1;
    logic [DW-1:0] iDATA  = '0;
    logic          iFVAL  = 1'b0;
    logic          iLVAL  = 1'b0;
    logic          iSTART = 1'b0;
    logic          iEND   = 1'b0;
    logic [DW-1:0] oDATA;
    logic          oDVAL;
    logic [XW-1:0] oX_Cont;
    logic [YW-1:0] oY_Cont;
    logic [31:0]   oFrame_Cont;
    logic          oBusy;

    ccd_capture #(
        .DATA_W     (DW),
        .X_W        (XW),
        .Y_W        (YW),
        .LINE_WIDTH (LW)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iDATA       (iDATA),
        .iFVAL       (iFVAL),
        .iLVAL       (iLVAL),
        .iSTART      (iSTART),
        .iEND        (iEND),
        .oDATA       (oDATA),
        .oDVAL       (oDVAL),
        .oX_Cont     (oX_Cont),
        .oY_Cont     (oY_Cont),
        .oFrame_Cont (oFrame_Cont),
        .oBusy       (oBusy)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [DW-1:0] data;
        int            x;
        int            y;
        int            cyc;
    } pix_t;

    pix_t exp_q[$];
    pix_t act_q[$];
    int   line_len[16];
    int   n_chk      = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   exp_frames = 0;

    // Record every valid output pixel with the cycle it appeared in
    always @(posedge iCLK) begin
        #1;
        cyc = cyc + 1;
        if (oDVAL === 1'b1) begin
            act_q.push_back('{data: oDATA, x: int'(oX_Cont), y: int'(oY_Cont), cyc: cyc});
        end
    end

    task automatic step(input logic [DW-1:0] d, input logic f, input logic l,
                        input logic s, input logic e);
        @(negedge iCLK);
        iDATA  = d;
        iFVAL  = f;
        iLVAL  = l;
        iSTART = s;
        iEND   = e;
    endtask

    task automatic idle(input int n);
        repeat (n) step(DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Drives one frame from line_len[]; returns right after FVAL is driven low.
    task automatic send_frame(input int nlines, input bit capture,
                              input int start_line, input int end_line);
        int            ybase = 0;
        logic [DW-1:0] d;
        step(DW'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        step(DW'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        for (int ln = 0; ln < nlines; ln++) begin
            for (int p = 0; p < line_len[ln]; p++) begin
                d = DW'($urandom);
                step(d, 1'b1, 1'b1, (ln == start_line && p == 0), (ln == end_line && p == 0));
                if (capture)
                    exp_q.push_back('{data: d, x: p % LW, y: ybase + p / LW, cyc: cyc});
            end
            ybase += (line_len[ln] + LW - 1) / LW;
            repeat (1 + $urandom_range(0, 1)) step(DW'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        if (capture) exp_frames++;
    endtask

    task automatic test_reset;
        iRST = 1'b1;
        repeat (3) @(posedge iCLK);
        #2;
        n_chk++; if (oDATA !== '0) begin n_fail++; $display("FAIL reset_data: got %h, expected 0", oDATA); end
        n_chk++; if (oDVAL !== 1'b0) begin n_fail++; $display("FAIL reset_dval: got %b, expected 0", oDVAL); end
        n_chk++; if (oX_Cont !== '0) begin n_fail++; $display("FAIL reset_x: got %0d, expected 0", oX_Cont); end
        n_chk++; if (oY_Cont !== '0) begin n_fail++; $display("FAIL reset_y: got %0d, expected 0", oY_Cont); end
        n_chk++; if (oFrame_Cont !== 32'd0) begin n_fail++; $display("FAIL reset_frames: got %0d, expected 0", oFrame_Cont); end
        n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", oBusy); end
        @(negedge iCLK);
        iRST = 1'b0;
        idle(2);
        $display("test_reset: done");
    endtask

    task automatic test_startup;
        act_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) line_len[i] = LW;
        step(DW'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        send_frame(4, 1'b1, -1, -1);
        idle(3);
        send_frame(4, 1'b1, -1, -1);
        idle(4);
        n_chk++;
        if (act_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL startup_count: got %0d pixels, expected %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            n_chk++;
            if (act_q[i].data !== exp_q[i].data || act_q[i].x !== exp_q[i].x ||
                act_q[i].y !== exp_q[i].y || (act_q[i].cyc - exp_q[i].cyc) !== 2) begin
                n_fail++;
                $display("FAIL startup_pix%0d: got d=%h x=%0d y=%0d lat=%0d, expected d=%h x=%0d y=%0d lat=2",
                         i, act_q[i].data, act_q[i].x, act_q[i].y, act_q[i].cyc - exp_q[i].cyc,
                         exp_q[i].data, exp_q[i].x, exp_q[i].y);
            end
        end
        n_chk++; if (oFrame_Cont !== 32'(exp_frames)) begin n_fail++; $display("FAIL startup_frames: got %0d, expected %0d", oFrame_Cont, exp_frames); end
        n_chk++; if (oBusy !== 1'b1) begin n_fail++; $display("FAIL startup_busy: got %b, expected 1", oBusy); end
        step(DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge iCLK); #2;
        n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL startup_stop_busy: got %b, expected 0", oBusy); end
        idle(2);
        $display("test_startup: %0d pixels, frames=%0d", act_q.size(), oFrame_Cont);
    endtask

    task automatic test_arm_mid_frame;
        act_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) line_len[i] = LW;
        send_frame(4, 1'b0, 1, -1);
        idle(3);
        send_frame(4, 1'b1, -1, -1);
        idle(4);
        n_chk++;
        if (act_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL arm_count: got %0d pixels, expected %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            n_chk++;
            if (act_q[i].data !== exp_q[i].data || act_q[i].x !== exp_q[i].x ||
                act_q[i].y !== exp_q[i].y || (act_q[i].cyc - exp_q[i].cyc) !== 2) begin
                n_fail++;
                $display("FAIL arm_pix%0d: got d=%h x=%0d y=%0d lat=%0d, expected d=%h x=%0d y=%0d lat=2",
                         i, act_q[i].data, act_q[i].x, act_q[i].y, act_q[i].cyc - exp_q[i].cyc,
                         exp_q[i].data, exp_q[i].x, exp_q[i].y);
            end
        end
        if (act_q.size() > 0) begin
            n_chk++;
            if (act_q[0].x !== 0 || act_q[0].y !== 0) begin
                n_fail++; $display("FAIL arm_first: got (%0d,%0d), expected (0,0)", act_q[0].x, act_q[0].y);
            end
        end
        n_chk++; if (oFrame_Cont !== 32'(exp_frames)) begin n_fail++; $display("FAIL arm_frames: got %0d, expected %0d", oFrame_Cont, exp_frames); end
        step(DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        $display("test_arm_mid_frame: %0d pixels, frames=%0d", act_q.size(), oFrame_Cont);
    endtask

    task automatic test_stop;
        act_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) line_len[i] = LW;
        step(DW'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        send_frame(4, 1'b1, -1, 2);
        @(posedge iCLK); #2;
        n_chk++; if (oBusy !== 1'b1) begin n_fail++; $display("FAIL stop_busy_hold: got %b, expected 1", oBusy); end
        @(posedge iCLK); #2;
        n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL stop_busy_drop: got %b, expected 0", oBusy); end
        idle(3);
        send_frame(4, 1'b0, -1, -1);
        idle(4);
        n_chk++;
        if (act_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL stop_count: got %0d pixels, expected %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            n_chk++;
            if (act_q[i].data !== exp_q[i].data || act_q[i].x !== exp_q[i].x ||
                act_q[i].y !== exp_q[i].y || (act_q[i].cyc - exp_q[i].cyc) !== 2) begin
                n_fail++;
                $display("FAIL stop_pix%0d: got d=%h x=%0d y=%0d lat=%0d, expected d=%h x=%0d y=%0d lat=2",
                         i, act_q[i].data, act_q[i].x, act_q[i].y, act_q[i].cyc - exp_q[i].cyc,
                         exp_q[i].data, exp_q[i].x, exp_q[i].y);
            end
        end
        n_chk++; if (oFrame_Cont !== 32'(exp_frames)) begin n_fail++; $display("FAIL stop_frames: got %0d, expected %0d", oFrame_Cont, exp_frames); end
        n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL stop_idle: got %b, expected 0", oBusy); end
        $display("test_stop: %0d pixels, frames=%0d", act_q.size(), oFrame_Cont);
    endtask

    task automatic test_short_line;
        act_q.delete(); exp_q.delete();
        line_len[0] = LW; line_len[1] = 5; line_len[2] = LW; line_len[3] = LW + 3;
        step(DW'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        send_frame(4, 1'b1, -1, -1);
        idle(4);
        n_chk++;
        if (act_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL short_count: got %0d pixels, expected %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            n_chk++;
            if (act_q[i].data !== exp_q[i].data || act_q[i].x !== exp_q[i].x ||
                act_q[i].y !== exp_q[i].y || (act_q[i].cyc - exp_q[i].cyc) !== 2) begin
                n_fail++;
                $display("FAIL short_pix%0d: got d=%h x=%0d y=%0d lat=%0d, expected d=%h x=%0d y=%0d lat=2",
                         i, act_q[i].data, act_q[i].x, act_q[i].y, act_q[i].cyc - exp_q[i].cyc,
                         exp_q[i].data, exp_q[i].x, exp_q[i].y);
            end
        end
        n_chk++; if (oFrame_Cont !== 32'(exp_frames)) begin n_fail++; $display("FAIL short_frames: got %0d, expected %0d", oFrame_Cont, exp_frames); end
        step(DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        $display("test_short_line: %0d pixels, frames=%0d", act_q.size(), oFrame_Cont);
    endtask

    task automatic test_simultaneous;
        act_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) line_len[i] = LW;
        step(DW'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge iCLK); #2;
        n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL simul_busy: got %b, expected 0", oBusy); end
        idle(2);
        send_frame(4, 1'b0, -1, -1);
        idle(4);
        n_chk++; if (act_q.size() !== 0) begin n_fail++; $display("FAIL simul_pixels: got %0d pixels, expected 0", act_q.size()); end
        n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL simul_idle: got %b, expected 0", oBusy); end
        n_chk++; if (oFrame_Cont !== 32'(exp_frames)) begin n_fail++; $display("FAIL simul_frames: got %0d, expected %0d", oFrame_Cont, exp_frames); end
        $display("test_simultaneous: busy=%b frames=%0d", oBusy, oFrame_Cont);
    endtask

    task automatic test_random;
        int nl;
        act_q.delete(); exp_q.delete();
        step(DW'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        repeat (3) begin
            nl = $urandom_range(2, 5);
            for (int i = 0; i < nl; i++) line_len[i] = $urandom_range(1, 2 * LW - 3);
            send_frame(nl, 1'b1, -1, -1);
            idle($urandom_range(2, 5));
        end
        idle(2);
        n_chk++;
        if (act_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL random_count: got %0d pixels, expected %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            n_chk++;
            if (act_q[i].data !== exp_q[i].data || act_q[i].x !== exp_q[i].x ||
                act_q[i].y !== exp_q[i].y || (act_q[i].cyc - exp_q[i].cyc) !== 2) begin
                n_fail++;
                $display("FAIL random_pix%0d: got d=%h x=%0d y=%0d lat=%0d, expected d=%h x=%0d y=%0d lat=2",
                         i, act_q[i].data, act_q[i].x, act_q[i].y, act_q[i].cyc - exp_q[i].cyc,
                         exp_q[i].data, exp_q[i].x, exp_q[i].y);
            end
        end
        n_chk++; if (oFrame_Cont !== 32'(exp_frames)) begin n_fail++; $display("FAIL random_frames: got %0d, expected %0d", oFrame_Cont, exp_frames); end
        step(DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        $display("test_random: %0d pixels, frames=%0d", act_q.size(), oFrame_Cont);
    endtask

    task automatic test_reset_mid_frame;
        logic [DW-1:0] d;
        act_q.delete(); exp_q.delete();
        step(DW'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        step(DW'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        step(DW'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < LW; p++) begin
            d = DW'($urandom);
            step(d, 1'b1, 1'b1, 1'b0, 1'b0);
            exp_q.push_back('{data: d, x: p, y: 0, cyc: cyc});
        end
        step(DW'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        // Reset lands while pixel (3,1) is on the outputs
        for (int p = 0; p < 6; p++) begin
            d = DW'($urandom);
            step(d, 1'b1, 1'b1, 1'b0, 1'b0);
            if (p <= 3) exp_q.push_back('{data: d, x: p, y: 1, cyc: cyc});
            if (p == 5) iRST = 1'b1;
        end
        @(posedge iCLK); #2;
        n_chk++; if (oDATA !== '0) begin n_fail++; $display("FAIL rstmid_data: got %h, expected 0", oDATA); end
        n_chk++; if (oDVAL !== 1'b0) begin n_fail++; $display("FAIL rstmid_dval: got %b, expected 0", oDVAL); end
        n_chk++; if (oX_Cont !== '0) begin n_fail++; $display("FAIL rstmid_x: got %0d, expected 0", oX_Cont); end
        n_chk++; if (oY_Cont !== '0) begin n_fail++; $display("FAIL rstmid_y: got %0d, expected 0", oY_Cont); end
        n_chk++; if (oFrame_Cont !== 32'd0) begin n_fail++; $display("FAIL rstmid_frames: got %0d, expected 0", oFrame_Cont); end
        n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, expected 0", oBusy); end
        exp_frames = 0;
        step(DW'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
        iRST = 1'b0;
        step(DW'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
        step(DW'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) begin
            repeat (LW) step(DW'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
            step(DW'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        n_chk++;
        if (act_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rstmid_count: got %0d pixels, expected %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            n_chk++;
            if (act_q[i].data !== exp_q[i].data || act_q[i].x !== exp_q[i].x ||
                act_q[i].y !== exp_q[i].y || (act_q[i].cyc - exp_q[i].cyc) !== 2) begin
                n_fail++;
                $display("FAIL rstmid_pix%0d: got d=%h x=%0d y=%0d lat=%0d, expected d=%h x=%0d y=%0d lat=2",
                         i, act_q[i].data, act_q[i].x, act_q[i].y, act_q[i].cyc - exp_q[i].cyc,
                         exp_q[i].data, exp_q[i].x, exp_q[i].y);
            end
        end
        n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %b, expected 0", oBusy); end
        n_chk++; if (oFrame_Cont !== 32'(exp_frames)) begin n_fail++; $display("FAIL rstmid_frames_after: got %0d, expected %0d", oFrame_Cont, exp_frames); end
        $display("test_reset_mid_frame: %0d pixels before reset", act_q.size());
    endtask

    initial begin
        test_reset();
        test_startup();
        test_arm_mid_frame();
        test_stop();
        test_short_line();
        test_simultaneous();
        test_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ccd_capture.md
# ccd_capture

Front-end capture stage between the camera sensor pins and the Bayer-to-grayscale/edge-filter stage. Registers the raw sensor bus, qualifies pixels with frame and line valid, and generates the per-pixel column and row coordinates and the data-valid strobe that the downstream stage consumes. Capture is gated by start/stop commands, so only whole frames are ever forwarded, and Bayer phase (X[0], Y[0]) always starts at 0,0.

## Interface
- `DATA_W`, 12, sensor pixel width
- `X_W`, 11, column counter width
- `Y_W`, 11, row counter width
- `LINE_WIDTH`, 1280, active pixels per line; the column counter wraps here
- `iCLK` in 1: pixel clock; single clock domain
- `iRST` in 1: reset, synchronous, active-high
- `iDATA` in DATA_W: raw sensor pixel
- `iFVAL` in 1: sensor frame valid
- `iLVAL` in 1: sensor line valid
- `iSTART` in 1: one-cycle pulse to arm capture
- `iEND` in 1: one-cycle pulse to stop capture
- `oDATA` out DATA_W: registered pixel
- `oDVAL` out 1: pixel valid (captured frame and line valid)
- `oX_Cont` out X_W: column of the pixel on `oDATA`
- `oY_Cont` out Y_W: row of the pixel on `oDATA`
- `oFrame_Cont` out 32: count of completed captured frames
- `oBusy` out 1: high in any state other than IDLE

## Operation
- Stage 1 registers `iDATA`, `iFVAL` and `iLVAL` into `mDATA`, `mFVAL` and `mLVAL`. All decisions use these registered copies.
- Edges are found by comparing each registered signal with its previous value.
- FSM states and transitions:
  - **IDLE**: on `iSTART`, go to SYNC.
  - **SYNC**: wait for `mFVAL`=0, then go to WAIT_SOF. This discards any frame already in progress.
  - **WAIT_SOF**: on a rising edge of `mFVAL`, go to ACTIVE.
  - **ACTIVE**: on a falling edge of `mFVAL`, increment `oFrame_Cont`. Then go to IDLE if `stop_pend` is set, otherwise to WAIT_SOF.
- `iEND` behaviour:
  - In SYNC or WAIT_SOF: go to IDLE immediately.
  - In ACTIVE: set `stop_pend`; the current frame completes before returning to IDLE.
  - In IDLE: ignored.
- If `iSTART` and `iEND` arrive in the same cycle, `iEND` wins.
- `iSTART` while busy is ignored.
- `oDVAL` = state is ACTIVE and `mLVAL`=1.
- Counter updates (applied only in ACTIVE):
  - On each valid pixel, X increments.
  - At X = LINE_WIDTH-1, X wraps to 0 and Y increments.
  - On a falling edge of `mLVAL` with X ≠ 0 (short line), X clears and Y increments.
  - On entering ACTIVE and on a falling edge of `mFVAL`, X and Y clear.
  - Y wraps modulo 2^Y_W; no saturation.
- `oFrame_Cont` wraps modulo 2^32 and is never cleared except by `iRST`.

## Timing
- Latency: a pixel sampled on `iDATA` at edge N appears on `oDATA` and `oDVAL` after edge N+1, i.e. 2 registers.
- `oX_Cont` and `oY_Cont` are the coordinates of the pixel on `oDATA` in the same cycle.
- `oX_Cont` and `oY_Cont` hold their values while `oDVAL`=0.
- `oDATA` is updated every cycle regardless of valid. Downstream must qualify it with `oDVAL`.
- The first `oDVAL` after a start is always pixel (0,0).
- Reset values: all outputs 0, state IDLE, `stop_pend` 0, stage-1 registers 0.
- Reset mid-frame: returns to IDLE within 1 cycle; no further `oDVAL`.
- `oFrame_Cont` updates 1 cycle after the `mFVAL` falling edge is detected.

## Structure
- Package `ccd_pkg`:
  - state enum `ccd_state_t` (IDLE, SYNC, WAIT_SOF, ACTIVE)
  - default `LINE_WIDTH`
  - width constants shared with the downstream filter stage
- Sub-module `ccd_edge_det`:
  - parameterised 1-bit rise/fall detector
  - instantiated once for `mFVAL` and once for `mLVAL`

## Test plan
- **Startup**: reset, `iSTART`, then 2 frames of 4 lines × LINE_WIDTH=8 pixels. Required: 32 `oDVAL` pulses per frame, X 0..7, Y 0..3, `oFrame_Cont`=2, data matches input delayed 2 cycles.
- **Arm mid-frame**: `iSTART` while `iFVAL`=1. Required: no `oDVAL` until the next `iFVAL` rise; the first captured pixel is (0,0).
- **Stop**: `iEND` at line 2 of frame 1. Required: frame 1 completes (32 pixels), `oFrame_Cont`=1, `oBusy` drops 1 cycle after the FVAL fall, and later frames are ignored.
- **Short line**: a 5-pixel line with LINE_WIDTH=8. Required: X 0..4, the next line starts at X=0 with Y+1.
- **Simultaneous commands**: `iSTART` and `iEND` in the same cycle from IDLE. Required: stays in IDLE, `oBusy`=0.
- **Reset mid-frame**: assert `iRST` at pixel (3,1). Required: next cycle all outputs are 0 and state is IDLE.
